// File: rtl/spi_xfer_pkg.sv
// Shared types and constants for the SPI transfer engine: FSM states,
// chip-select guard lengths and the frame bit-count helper.
package spi_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } xfer_state_t;

    localparam int CS_SETUP_CYCLES = 1;
    localparam int CS_HOLD_CYCLES  = 1;

    // Total bits on the wire: command, optional address, clamped data bytes.
    function automatic int bit_count(input logic has_addr, input int nbytes,
                                     input int addr_bytes, input int max_bytes);
        int n_data;
        n_data = (nbytes > max_bytes) ? max_bytes : nbytes;
        return 8 + (has_addr ? 8 * addr_bytes : 0) + 8 * n_data;
    endfunction

endpackage

// File: rtl/spi_xfer_clkgen.sv
// SCLK generator: holds each sclk level for (i_half_m1 + 1) clk cycles while
// enabled and flags the cycle whose closing edge makes sclk rise or fall.
module spi_xfer_clkgen (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_half_m1,
    output logic       o_sclk,
    output logic       o_rise,
    output logic       o_fall
);

    logic [7:0] r_cnt;
    logic       r_level;
    logic       w_phase_end;

    assign w_phase_end = i_en && (r_cnt == i_half_m1);

    // Dropping the enable parks the generator low so each transfer starts in phase.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_level <= !r_level;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_sclk = r_level;
    assign o_rise = w_phase_end && !r_level;
    assign o_fall = w_phase_end && r_level;

endmodule

// File: rtl/spi_xfer_engine.sv
// SPI mode-0 command/address/data transfer engine with selectable chip select.
// Define SPI_XFER_CLKDIV_EN to add cfg_div, stretching each sclk half-period to cfg_div+1 cycles.
module spi_xfer_engine
    import spi_xfer_pkg::*;
#(
    parameter  int ADDR_BYTES     = 3,
    parameter  int MAX_DATA_BYTES = 4,
    parameter  int NUM_CS         = 2,
    localparam int CS_W           = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int NB_W           = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [CS_W-1:0]             req_cs,
    input  logic [7:0]                  req_cmd,
    input  logic                        req_has_addr,
    input  logic [8*ADDR_BYTES-1:0]     req_addr,
    input  logic [NB_W-1:0]             req_nbytes,
    input  logic                        req_is_write,
    input  logic [8*MAX_DATA_BYTES-1:0] req_wdata,
`ifdef SPI_XFER_CLKDIV_EN
    input  logic [7:0]                  cfg_div,
`endif
    output logic                        rsp_valid,
    output logic [8*MAX_DATA_BYTES-1:0] rsp_rdata,
    output logic                        busy,
    output logic                        sclk,
    output logic                        mosi,
    input  logic                        miso,
    output logic [NUM_CS-1:0]           cs_n
);

    localparam int DATA_W  = 8 * MAX_DATA_BYTES;
    localparam int FRAME_W = 8 * (1 + ADDR_BYTES + MAX_DATA_BYTES);
    localparam int BITS_W  = $clog2(FRAME_W + 1);
    localparam int DIDX_W  = $clog2(DATA_W);
    localparam int WAIT_W  = 4;

    xfer_state_t        r_state;
    xfer_state_t        w_state_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [CS_W-1:0]    r_cs;
    logic [FRAME_W-1:0] r_frame;
    logic [BITS_W-1:0]  r_nbits;
    logic [BITS_W-1:0]  r_hdr_bits;
    logic [BITS_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_accept;
    logic               w_shift_en;
    logic               w_cs_active;
    logic               w_level;
    logic               w_rise;
    logic               w_fall;
    logic               w_last_bit;
    logic               w_in_data;
    logic [DIDX_W-1:0]  w_rx_pos;
    logic [7:0]         w_half_m1;
    logic [DATA_W-1:0]  w_data_field;
    logic [FRAME_W-1:0] w_frame;

    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

`ifdef SPI_XFER_CLKDIV_EN
    logic [7:0] r_half_m1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half_m1 <= '0;
        end else if (w_accept) begin
            r_half_m1 <= cfg_div;
        end
    end

    assign w_half_m1 = r_half_m1;
`else
    assign w_half_m1 = 8'd0;
`endif

    // Data byte 0 goes out first, so it sits at the top of the data field.
    generate
        for (genvar gi = 0; gi < MAX_DATA_BYTES; gi++) begin : g_data_field
            assign w_data_field[DATA_W-8*gi-1 -: 8] = req_is_write ? req_wdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign w_frame = req_has_addr ? {req_cmd, req_addr, w_data_field}
                                  : {req_cmd, w_data_field, {(8*ADDR_BYTES){1'b0}}};

    spi_xfer_clkgen u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_shift_en),
        .i_half_m1 (w_half_m1),
        .o_sclk    (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_shift_en = (r_state == SHIFT);
    assign w_last_bit = (r_bit_idx == r_nbits - 1'b1);
    assign w_in_data  = (r_bit_idx >= r_hdr_bits);
    // Data bit d lands in byte d/8 at position 7-(d%8): flip the low three bits.
    assign w_rx_pos   = DIDX_W'(r_bit_idx - r_hdr_bits) ^ DIDX_W'(7);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept) w_state_next = CS_SETUP;
            CS_SETUP: if (r_wait == WAIT_W'(CS_SETUP_CYCLES - 1)) w_state_next = SHIFT;
            SHIFT:    if (w_fall && w_last_bit) w_state_next = CS_HOLD;
            CS_HOLD:  if (r_wait == WAIT_W'(CS_HOLD_CYCLES - 1)) w_state_next = DONE;
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= (w_state_next != r_state) ? '0 : r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs       <= '0;
            r_frame    <= '0;
            r_nbits    <= '0;
            r_hdr_bits <= '0;
            r_bit_idx  <= '0;
            r_rdata    <= '0;
        end else if (w_accept) begin
            r_cs       <= req_cs;
            r_frame    <= w_frame;
            r_nbits    <= BITS_W'(bit_count(req_has_addr, int'(req_nbytes), ADDR_BYTES, MAX_DATA_BYTES));
            r_hdr_bits <= BITS_W'(bit_count(req_has_addr, 0, ADDR_BYTES, MAX_DATA_BYTES));
            r_bit_idx  <= '0;
            r_rdata    <= '0;
        end else if (w_shift_en) begin
            if (w_rise && w_in_data) begin
                r_rdata[w_rx_pos] <= miso;
            end
            if (w_fall) begin
                r_frame   <= {r_frame[FRAME_W-2:0], 1'b0};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    assign w_cs_active = ((r_state == CS_SETUP) || (r_state == SHIFT) || (r_state == CS_HOLD)) && !rst;

    // An out-of-range index matches no line, so every select stays high.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_n[gi] = !(w_cs_active && (r_cs == CS_W'(gi)));
        end
    endgenerate

    assign sclk      = w_level && w_shift_en && !rst;
    assign mosi      = r_frame[FRAME_W-1] && w_shift_en && !rst;
    assign rsp_valid = (r_state == DONE) && !rst;
    assign busy      = (r_state != IDLE) && !rst;
    assign rsp_rdata = r_rdata;

endmodule
